// File: rtl/mem_sram_ctrl_if.sv
// EX/MEM-side handshake for the SRAM controller: the request and address/data from EX,
// plus the load result and the ready flag that drives the pipeline freeze.
interface mem_sram_ctrl_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Result;
    logic [31:0] Val_Rm;
    logic [31:0] Read_Data;
    logic        ready;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
        input  Read_Data, ready
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
        output Read_Data, ready
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller that performs 32-bit loads and stores against a 16-bit asynchronous
// SRAM as two half-word accesses, holding ready low while the access is in flight.
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    mem_sram_ctrl_if.slave    ex,
    output logic [17:0]       SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [15:0]     cap_lo_reg, cap_lo_next;
    logic [31:0]     read_data_reg, read_data_next;
    logic [17:0]     sram_addr_reg, sram_addr_next;
    logic            ready_c;
    logic            last_wait;
    logic            dq_oe;
    logic [15:0]     dq_out;
    logic [31:0]     offset;
    logic [16:0]     req_word;

    // Word index wraps modulo 2^17; byte offset within the word is dropped.
    assign offset   = ex.ALU_Result - BASE_ADDR;
    assign req_word = offset[18:2];
    wire   unused_offset = &{1'b0, offset[31:19], offset[1:0]};

    assign last_wait = (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        wdata_next     = wdata_reg;
        cap_lo_next    = cap_lo_reg;
        read_data_next = read_data_reg;
        sram_addr_next = sram_addr_reg;
        ready_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c       = ~(ex.MEM_R_EN | ex.MEM_W_EN);
                wait_cnt_next = '0;
                if (ex.MEM_W_EN || ex.MEM_R_EN) begin
                    wdata_next     = ex.Val_Rm;
                    sram_addr_next = {req_word, 1'b0};
                    state_next     = ex.MEM_W_EN ? WR_LO : RD_LO;
                end
            end
            WR_LO, RD_LO: begin
                if (last_wait) begin
                    wait_cnt_next  = '0;
                    sram_addr_next = {sram_addr_reg[17:1], 1'b1};
                    if (state_reg == RD_LO) begin
                        cap_lo_next = SRAM_DQ;
                        state_next  = RD_HI;
                    end else begin
                        state_next  = WR_HI;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            WR_HI, RD_HI: begin
                if (last_wait) begin
                    wait_cnt_next = '0;
                    state_next    = DONE;
                    // The result lands at DONE entry so it is already valid while ready is high.
                    if (state_reg == RD_HI)
                        read_data_next = {SRAM_DQ, cap_lo_reg};
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                ready_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            wdata_reg     <= '0;
            cap_lo_reg    <= '0;
            read_data_reg <= '0;
            sram_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            wdata_reg     <= wdata_next;
            cap_lo_reg    <= cap_lo_next;
            read_data_reg <= read_data_next;
            sram_addr_reg <= sram_addr_next;
        end
    end

    // Strobes come straight from the state register, so WE_N stays low across both write halves.
    assign dq_oe     = (state_reg == WR_LO) || (state_reg == WR_HI);
    assign dq_out    = (state_reg == WR_HI) ? wdata_reg[31:16] : wdata_reg[15:0];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_WE_N = ~dq_oe;
    assign SRAM_OE_N = ~((state_reg == RD_LO) || (state_reg == RD_HI));
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = sram_addr_reg;

    assign ex.ready     = ready_c;
    assign ex.Read_Data = read_data_reg;
endmodule
